// File: rtl/tgif_state_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tgif_state_load_ctrl: loads NWORDS state words over valid/ready, then    |
// | runs ROUNDS round cycles on the state registers; one-cycle init clear.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tgif_state_load_ctrl #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 4,
  parameter int ROUNDS = 48,
  parameter int RW     = 6,
  parameter int IW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [WIDTH-1:0]  si,
  output logic [NWORDS-1:0] enc,
  output logic              se,
  output logic              sr_init,
  output logic [RW-1:0]     round,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IW-1:0] c_LAST_IDX = IW'(NWORDS - 1);
  localparam logic [RW-1:0] c_LAST_RND = RW'(ROUNDS - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     rnd_q, rnd_d;
  logic [NWORDS-1:0] w_onehot;
  logic              w_fire;

  // Load data goes straight through; only the enables decide who captures it.
  assign si = din;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NWORDS; i++) begin
      w_onehot[i] = (idx_q == IW'(i));
    end
  end

  assign w_fire = (state_q == S_LOAD) && din_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rnd_d   = rnd_q;
    case (state_q)
      S_IDLE: begin
        // clear wins; a simultaneous start is dropped rather than queued
        if (clear) begin
          state_d = S_CLEAR;
        end else if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      S_LOAD: begin
        if (w_fire) begin
          if (idx_q == c_LAST_IDX) begin
            state_d = S_RUN;
            idx_d   = '0;
            rnd_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (rnd_q == c_LAST_RND) begin
          state_d = S_DONE;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        rnd_d   = '0;
      end
    endcase
  end

  // Outputs decode from the state register only, so reset removes them at once.
  always_comb begin
    din_ready = 1'b0;
    enc       = '0;
    se        = 1'b0;
    sr_init   = 1'b0;
    round     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        enc     = '1;
        se      = 1'b1;
        sr_init = 1'b1;
        busy    = 1'b1;
      end
      S_LOAD: begin
        din_ready = 1'b1;
        se        = 1'b1;
        busy      = 1'b1;
        enc       = din_valid ? w_onehot : '0;
      end
      S_RUN: begin
        enc   = '1;
        round = rnd_q;
        busy  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tgif_state_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tgif_state_load_ctrl: directed bench with a behavioural model and a   |
// | model of the downstream state registers. Revision: 1.0                   |
// +--------------------------------------------------------------------------+
module tb_tgif_state_load_ctrl;
  localparam int WIDTH  = 32;
  localparam int NWORDS = 4;
  localparam int ROUNDS = 48;
  localparam int RW     = 6;
  localparam int IW     = 2;
  localparam logic [WIDTH-1:0] INIT = 32'h5555_5555;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              clear = 1'b0;
  logic [WIDTH-1:0]  din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic [WIDTH-1:0]  si;
  logic [NWORDS-1:0] enc;
  logic              se;
  logic              sr_init;
  logic [RW-1:0]     round;
  logic              busy;
  logic              done;

  tgif_state_load_ctrl #(
    .WIDTH(WIDTH), .NWORDS(NWORDS), .ROUNDS(ROUNDS), .RW(RW), .IW(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .si(si), .enc(enc),
    .se(se), .sr_init(sr_init), .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = -1;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the transaction plus how far it has progressed.
  localparam int M_IDLE = 0, M_CLEAR = 1, M_LOAD = 2, M_RUN = 3, M_DONE = 4;
  int m_phase = M_IDLE;
  int m_words = 0;
  int m_rounds = 0;

  // Downstream registers: one copy fed by the model, one fed by the DUT outputs.
  logic [WIDTH-1:0] reg_m [NWORDS];
  logic [WIDTH-1:0] reg_d [NWORDS];

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      reg_m[i] = '0;
      reg_d[i] = '0;
    end
  end

  always @(negedge clk) begin
    logic [NWORDS-1:0] e_enc;
    logic              e_se, e_init, e_ready, e_busy, e_done;
    logic [RW-1:0]     e_round;
    if (!rst) begin
      m_phase = M_IDLE; m_words = 0; m_rounds = 0;
    end
    e_enc = '0; e_se = 0; e_init = 0; e_ready = 0; e_busy = 0; e_done = 0; e_round = '0;
    case (m_phase)
      M_CLEAR: begin e_enc = '1; e_se = 1; e_init = 1; e_busy = 1; end
      M_LOAD: begin
        e_ready = 1; e_se = 1; e_busy = 1;
        if (din_valid) e_enc = NWORDS'(1) << m_words;
      end
      M_RUN: begin e_enc = '1; e_busy = 1; e_round = RW'(m_rounds); end
      M_DONE: e_done = 1;
      default: ;
    endcase
    chk("enc", 64'(enc), 64'(e_enc));
    chk("se", 64'(se), 64'(e_se));
    chk("sr_init", 64'(sr_init), 64'(e_init));
    chk("din_ready", 64'(din_ready), 64'(e_ready));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("round", 64'(round), 64'(e_round));
    chk("si", 64'(si), 64'(din));
    if (done === 1'b1) begin done_cyc = cyc; done_cnt++; end

    // Register updates that the coming rising edge will perform.
    for (int i = 0; i < NWORDS; i++) begin
      if (e_enc[i]) reg_m[i] = e_se ? (e_init ? INIT : din) : reg_m[i] + WIDTH'(e_round);
      if (enc[i])   reg_d[i] = se ? (sr_init ? INIT : si) : reg_d[i] + WIDTH'(round);
    end

    if (rst) begin
      case (m_phase)
        M_IDLE: begin
          if (clear) m_phase = M_CLEAR;
          else if (start) begin m_phase = M_LOAD; m_words = 0; end
        end
        M_LOAD: if (din_valid) begin
          m_words++;
          if (m_words == NWORDS) begin m_phase = M_RUN; m_words = 0; m_rounds = 0; end
        end
        M_RUN: begin
          m_rounds++;
          if (m_rounds == ROUNDS) begin m_phase = M_DONE; m_rounds = 0; end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int prev_cnt, input string name);
    int n;
    n = 0;
    while (done_cnt == prev_cnt && n < 200) begin tick(); n++; end
    chk({name, "_timeout"}, 64'(n < 200), 64'd1);
  endtask

  task automatic chk_regs(input string name);
    for (int i = 0; i < NWORDS; i++) chk(name, 64'(reg_d[i]), 64'(reg_m[i]));
  endtask

  initial begin
    int k, prev, n;
    logic [6:0] pat;

    // Reset state
    tick(); tick();
    chk("rst_enc", 64'(enc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    rst = 1'b1;
    tick();

    // Clear: one init cycle, then idle
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_enc", 64'(enc), 64'hF);
    chk("clr_se", 64'(se), 64'd1);
    chk("clr_init", 64'(sr_init), 64'd1);
    tick();
    chk("clr_after_busy", 64'(busy), 64'd0);
    for (int i = 0; i < NWORDS; i++) chk("clr_reg", 64'(reg_d[i]), 64'(INIT));

    // Clear and start together: clear only, start dropped
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    chk("cs_init", 64'(sr_init), 64'd1);
    chk("cs_ready", 64'(din_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin tick(); chk("cs_no_load", 64'(busy), 64'd0); end

    // Full run with din_valid held high
    start = 1'b1; din_valid = 1'b1; din = 32'hA0; k = cyc; prev = done_cnt;
    tick(); start = 1'b0;
    for (int j = 0; j < NWORDS; j++) begin
      chk("run_enc", 64'(enc), 64'(4'b0001 << j));
      chk("run_si", 64'(si), 64'(32'hA0 + j));
      tick(); din = din + 1;
    end
    din_valid = 1'b0;
    chk("run_se0", 64'(se), 64'd0);
    wait_done(prev, "run");
    chk("run_done_cyc", 64'(done_cyc), 64'(k + NWORDS + ROUNDS + 1));
    chk("run_reg0", 64'(reg_d[0]), 64'h508);
    chk("run_reg3", 64'(reg_d[3]), 64'h50B);
    chk_regs("run_regs");
    tick(); tick();

    // Stalled load: valid pattern 1,0,0,1,1,0,1
    pat = 7'b1011001;
    start = 1'b1; din = 32'hB0; tick(); start = 1'b0;
    for (int j = 0; j < 7; j++) begin
      din_valid = pat[j];
      #1;
      if (!pat[j]) chk("stall_enc", 64'(enc), 64'd0);
      chk("stall_se", 64'(se), 64'd1);
      tick();
      if (pat[j]) din = din + 1;
    end
    din_valid = 1'b0;
    chk("stall_run", 64'(se), 64'd0);
    chk("stall_enc_run", 64'(enc), 64'hF);
    prev = done_cnt;
    wait_done(prev, "stall");
    chk_regs("stall_regs");
    tick();

    // Ignored requests: start during RUN and in the DONE cycle
    start = 1'b1; din_valid = 1'b1; din = 32'hC0; k = cyc; prev = done_cnt;
    tick(); start = 1'b0;
    for (int j = 0; j < NWORDS; j++) begin tick(); din = din + 1; end
    din_valid = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    chk("ign_timeout", 64'(n < 100), 64'd1);
    start = 1'b1; #1;
    chk("ign_done_cyc", 64'(cyc), 64'(k + NWORDS + ROUNDS + 1));
    tick(); start = 1'b0;
    for (int j = 0; j < 3; j++) begin tick(); chk("ign_idle", 64'(busy), 64'd0); end
    chk_regs("ign_regs");

    // Reset mid-RUN at round 20
    start = 1'b1; din_valid = 1'b1; din = 32'hD0; tick(); start = 1'b0;
    for (int j = 0; j < NWORDS; j++) begin tick(); din = din + 1; end
    din_valid = 1'b0;
    n = 0;
    while (round !== 6'd20 && n < 100) begin tick(); n++; end
    chk("rstm_reach20", 64'(n < 100), 64'd1);
    #2 rst = 1'b0; #1;
    chk("rstm_enc", 64'(enc), 64'd0);
    chk("rstm_busy", 64'(busy), 64'd0);
    chk("rstm_ready", 64'(din_ready), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rstm_idle", 64'(busy), 64'd0);
    chk("rstm_round", 64'(round), 64'd0);
    chk_regs("rstm_regs");
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/tgif_state_load_ctrl.md
Name: tgif_state_load_ctrl

Overview:
- Control and load stage directly upstream of the per-word state registers (enable/select state registers with an init path).
- Accepts the initial state one word at a time over a valid/ready handshake and steers each word into its register (one-hot enables, select=load).
- Then runs ROUNDS cycles with all registers enabled and select=round-function, and pulses done.
- Also provides a one-cycle clear that forces every state register to its initial value.

Parameters:
- WIDTH, 32, width of one state word; must match the downstream register width.
- NWORDS, 4, number of state registers / words per state.
- ROUNDS, 48, round-function cycles per run; must be at least 1.
- RW, 6, width of the round counter; requires 2^RW >= ROUNDS.
- IW, 2, width of the word index; requires 2^IW >= NWORDS.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-low reset (0 = reset).
- start, input, 1, begin load+run; sampled only in IDLE.
- clear, input, 1, request init of all state registers; sampled only in IDLE; priority over start.
- din, input, WIDTH, state word being loaded.
- din_valid, input, 1, din holds a valid word.
- din_ready, output, 1, block accepts din this cycle.
- si, output, WIDTH, load data to the state registers; equals din (combinational).
- enc, output, NWORDS, per-register enable.
- se, output, 1, register select: 1 = load path (si/init), 0 = round function.
- sr_init, output, 1, drives the state registers' init input; forces the initial value on the load path.
- round, output, RW, current round index, valid while busy=1 in RUN; for round constants.
- busy, output, 1, high in CLEAR, LOAD and RUN.
- done, output, 1, one-cycle pulse when a run completes.

Behaviour:
- States: IDLE, CLEAR, LOAD, RUN, DONE. State register, idx and rnd are async-cleared by rst=0.
- Reset values: state=IDLE, idx=0, rnd=0. While reset is asserted and afterwards in IDLE, all outputs read 0 except si, which follows din.
- IDLE: enc=0, se=0, din_ready=0, done=0.
  - clear=1 -> CLEAR.
  - else start=1 -> LOAD with idx=0.
  - clear and start high together -> CLEAR; start is dropped, not queued.
- CLEAR (exactly 1 cycle): enc all ones, se=1, sr_init=1, busy=1 -> IDLE.
- LOAD: din_ready=1, se=1, sr_init=0, busy=1; enc = onehot(idx) gated by din_valid.
  - Handshake fires when din_valid and din_ready are both 1; idx then increments.
  - When the fire happens at idx=NWORDS-1 -> RUN, rnd=0, idx=0.
  - din_valid low stalls LOAD indefinitely with enc=0; no register changes.
  - Word k of the transfer lands in register k (0 first).
- RUN: enc all ones, se=0, din_ready=0, round=rnd, busy=1.
  - rnd increments each cycle; at rnd=ROUNDS-1 -> DONE and rnd=0.
  - Exactly ROUNDS enabled round cycles; no stall input.
- DONE (1 cycle): done=1, enc=0, busy=0 -> IDLE.
- start and clear are ignored outside IDLE.
- Latency: with din_valid held high and start sampled at edge k, LOAD occupies cycles k+1..k+NWORDS, RUN occupies the next ROUNDS cycles, and done is high in cycle k+NWORDS+ROUNDS+1.
- Reset mid-operation: immediate return to IDLE; enc and din_ready drop asynchronously; partially loaded state is left in the registers untouched.
- Counter wrap: idx and rnd never exceed NWORDS-1 / ROUNDS-1; no modular wrap is relied on.

Test Plan:
- Reset: rst=0 mid-RUN (rnd=20) -> enc=0, busy=0, din_ready=0 immediately; after release the block is in IDLE and round=0.
- Clear: clear=1 in IDLE -> one cycle with enc=4'b1111, se=1, sr_init=1, then IDLE.
- Clear+start: clear=1 and start=1 in the same IDLE cycle -> CLEAR only; no LOAD follows.
- Full run, defaults: start, din_valid held high with words 0xA0..0xA3 -> enc 0001, 0010, 0100, 1000 with si=0xA0..0xA3; 48 cycles of enc=1111, se=0, round=0..47; done high exactly at cycle k+53; registers match a reference model.
- Stalled load: din_valid toggled 1,0,0,1,1,0,1 -> enc=0 and idx frozen on every low cycle; RUN entered only after the 4th accepted word.
- Ignored requests: start=1 during RUN -> no restart, done still at the expected cycle. start=1 in the DONE cycle -> ignored, state returns to IDLE.
